// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Executes one operation at a time. NOP/ADD/SUB/AND/OR/NOT finish in one
// cycle. MUL (shift-add) and DIV (restoring) take WIDTH iterations.
// Status flags are reported with the result.
//
// Optional feature macro: ALU_HI_RESULT_EN
//   When defined, adds port result_hi. For MUL it carries the upper half of
//   the product. For DIV it carries the remainder, or A when B==0. It is 0
//   for every other op.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   request valid          in_ready   block can accept a request
//   op         3-bit opcode           operand_1  A, operand_2 B
//   out_valid  result valid           out_ready  consumer takes the result
//   result     WIDTH-bit result
//   flag_zero / flag_carry / flag_ovf / flag_div0   status flags
//   result_hi  (ALU_HI_RESULT_EN only) high product / remainder
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_div0
`ifdef ALU_HI_RESULT_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    // MUL: running product {hi, lo}; B sits in the low half and shifts out.
    // DIV: {partial remainder, quotient}; A sits in the low half and
    // shifts out as quotient bits shift in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic               r_div0;
`ifdef ALU_HI_RESULT_EN
    logic [WIDTH-1:0]   r_result_hi;
`endif

    logic               w_accept;
    logic [WIDTH-1:0]   w_fast_res;
    logic               w_fast_carry;
    logic [WIDTH:0]     w_wide;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step_next;
    logic               w_last;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_ovf   = r_ovf;
    assign flag_div0  = r_div0;
`ifdef ALU_HI_RESULT_EN
    assign result_hi  = r_result_hi;
`endif

    // Single-cycle ops are evaluated straight from the request inputs.
    always_comb begin
        w_fast_res   = '0;
        w_fast_carry = 1'b0;
        w_wide       = '0;
        case (op)
            OP_ADD: begin
                w_wide       = {1'b0, operand_1} + {1'b0, operand_2};
                w_fast_res   = w_wide[WIDTH-1:0];
                w_fast_carry = w_wide[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the wrapped difference is the borrow (A<B).
                w_wide       = {1'b0, operand_1} - {1'b0, operand_2};
                w_fast_res   = w_wide[WIDTH-1:0];
                w_fast_carry = w_wide[WIDTH];
            end
            OP_AND:  w_fast_res = operand_1 & operand_2;
            OP_OR:   w_fast_res = operand_1 | operand_2;
            OP_NOT:  w_fast_res = ~operand_1;
            default: w_fast_res = '0;
        endcase
    end

    // One iteration of the MUL or DIV datapath.
    always_comb begin
        // Shift-add: add A to the high half when the current B bit is set,
        // then shift the whole product right by one.
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : '0)};
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Restoring division: shift the next dividend bit into the
        // remainder and subtract B if it fits. Because the remainder stays
        // below B, the difference always fits in WIDTH bits. With B==0 every
        // step subtracts nothing. The quotient then becomes all ones and the
        // remainder collects A.
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
        w_div_next  = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                               : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

        w_step_next = (r_op == OP_MUL) ? w_mul_next : w_div_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NOP;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_div0   <= 1'b0;
`ifdef ALU_HI_RESULT_EN
            r_result_hi <= '0;
`endif
        end else if (w_accept) begin
            // An accept is only possible from IDLE, or from DONE when the
            // result is being consumed on the same cycle.
            r_op  <= op;
            r_a   <= operand_1;
            r_b   <= operand_2;
            r_cnt <= '0;
            if (op == OP_MUL || op == OP_DIV) begin
                r_state <= S_BUSY;
                r_acc   <= (op == OP_MUL) ? {{WIDTH{1'b0}}, operand_2}
                                          : {{WIDTH{1'b0}}, operand_1};
            end else begin
                r_state  <= S_DONE;
                r_result <= w_fast_res;
                r_zero   <= (w_fast_res == '0);
                r_carry  <= w_fast_carry;
                r_ovf    <= 1'b0;
                r_div0   <= 1'b0;
`ifdef ALU_HI_RESULT_EN
                r_result_hi <= '0;
`endif
            end
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_acc <= w_step_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_result <= w_step_next[WIDTH-1:0];
                        r_zero   <= (w_step_next[WIDTH-1:0] == '0);
                        r_carry  <= 1'b0;
                        r_ovf    <= (r_op == OP_MUL) && (|w_step_next[2*WIDTH-1:WIDTH]);
                        r_div0   <= (r_op == OP_DIV) && (r_b == '0);
`ifdef ALU_HI_RESULT_EN
                        r_result_hi <= w_step_next[2*WIDTH-1:WIDTH];
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=16).
// Applies a table of directed vectors with hand-computed results. Then it
// runs hand-written sequences for output stall, back-to-back issue, and
// reset during a multi-cycle op.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;
    logic         flag_div0;
`ifdef ALU_HI_RESULT_EN
    logic [W-1:0] result_hi;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .flag_div0  (flag_div0)
`ifdef ALU_HI_RESULT_EN
        ,
        .result_hi  (result_hi)
`endif
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
        logic         d;
        logic [W-1:0] hi;
        int           lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Issue one op with out_ready=1. Returns on the negedge where out_valid
    // is first seen, or after a bounded wait.
    task automatic issue_and_wait(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        operand_1 = a;
        operand_2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        //           op    A        B        result   z  c  o  d  hi       lat
        vecs[0]  = '{3'd1, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0, 16'h0000, 1};
        vecs[1]  = '{3'd2, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 0, 16'h0000, 1};
        vecs[2]  = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, 16'h0000, 1};
        vecs[3]  = '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 0, 1, 0, 0, 16'h0000, 1};
        vecs[4]  = '{3'd3, 16'h0002, 16'h0002, 16'h0004, 0, 0, 0, 0, 16'h0000, 17};
        vecs[5]  = '{3'd3, 16'h0100, 16'h0100, 16'h0000, 1, 0, 1, 0, 16'h0001, 17};
        vecs[6]  = '{3'd4, 16'h0004, 16'h0002, 16'h0002, 0, 0, 0, 0, 16'h0000, 17};
        vecs[7]  = '{3'd4, 16'h0007, 16'h0000, 16'hFFFF, 0, 0, 0, 1, 16'h0007, 17};
        vecs[8]  = '{3'd5, 16'h0005, 16'h0004, 16'h0004, 0, 0, 0, 0, 16'h0000, 1};
        vecs[9]  = '{3'd6, 16'h0005, 16'h0004, 16'h0005, 0, 0, 0, 0, 16'h0000, 1};
        vecs[10] = '{3'd7, 16'hAAAA, 16'h1234, 16'h5555, 0, 0, 0, 0, 16'h0000, 1};
        vecs[11] = '{3'd0, 16'h0003, 16'h0004, 16'h0000, 1, 0, 0, 0, 16'h0000, 1};
        vecs[12] = '{3'd4, 16'd100,  16'd7,    16'd14,   0, 0, 0, 0, 16'd2,    17};
        vecs[13] = '{3'd3, 16'h1234, 16'h0010, 16'h2340, 0, 0, 1, 0, 16'h0001, 17};
        vecs[14] = '{3'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 1, 0, 16'hFFFE, 17};

        // Reset held for two cycles, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result",    32'(result),    32'd0);
        check("reset flags",     32'({flag_zero, flag_carry, flag_ovf, flag_div0}), 32'd0);
        $display("[TB] reset: in_ready=%0d out_valid=%0d result=%0h", in_ready, out_valid, result);

        for (int i = 0; i < NV; i++) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d latency", i), 32'(lat),        32'(vecs[i].lat));
            check($sformatf("v%0d result", i),  32'(result),     32'(vecs[i].res));
            check($sformatf("v%0d zero", i),    32'(flag_zero),  32'(vecs[i].z));
            check($sformatf("v%0d carry", i),   32'(flag_carry), 32'(vecs[i].c));
            check($sformatf("v%0d ovf", i),     32'(flag_ovf),   32'(vecs[i].o));
            check($sformatf("v%0d div0", i),    32'(flag_div0),  32'(vecs[i].d));
`ifdef ALU_HI_RESULT_EN
            check($sformatf("v%0d result_hi", i), 32'(result_hi), 32'(vecs[i].hi));
`endif
            $display("[TB] vec %0d op=%0d A=%h B=%h -> result=%h z=%0d c=%0d o=%0d d=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, result, flag_zero, flag_carry,
                     flag_ovf, flag_div0, lat);
        end

        // Output stall: result held for 3 cycles with out_ready low.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; operand_1 = 16'd3; operand_2 = 16'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check("stall first valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d result", k),    32'(result),    32'd7);
            check($sformatf("stall%0d in_ready", k),  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall release out_valid", 32'(out_valid), 32'd0);
        check("stall release in_ready",  32'(in_ready),  32'd1);
        $display("[TB] stall: result held at 7 for 3 cycles, released");

        // Back-to-back: a new op accepted while the previous result drains.
        in_valid = 1'b1; op = 3'd6; operand_1 = 16'd1; operand_2 = 16'd2;
        @(negedge clk);
        check("b2b first valid",    32'(out_valid), 32'd1);
        check("b2b first result",   32'(result),    32'd3);
        check("b2b in_ready",       32'(in_ready),  32'd1);
        op = 3'd1; operand_1 = 16'd5; operand_2 = 16'd6;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b second valid",  32'(out_valid), 32'd1);
        check("b2b second result", 32'(result),    32'd11);
        @(negedge clk);
        check("b2b drained", 32'(out_valid), 32'd0);
        $display("[TB] back-to-back: OR->3 then ADD->%0d with zero bubble", result);

        // Reset during a busy MUL aborts it.
        in_valid = 1'b1; op = 3'd3; operand_1 = 16'd3; operand_2 = 16'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy out_valid", 32'(out_valid), 32'd0);
        check("busy in_ready",  32'(in_ready),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready",  32'(in_ready),  32'd1);
        check("abort result",    32'(result),    32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no late result", 32'(seen), 32'd0);
        $display("[TB] reset mid-MUL: aborted, out_valid seen %0d times afterwards", seen);

        // The block still works after the abort.
        issue_and_wait(3'd3, 16'd3, 16'd3, lat);
        check("post-abort latency", 32'(lat),    32'd17);
        check("post-abort result",  32'(result), 32'd9);
        $display("[TB] post-abort MUL 3*3 -> %0d lat=%0d", result, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
